// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - port bundle between the arbiter, the IF/MEM stages and the memory
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // IF stage
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // MEM stage
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // pipeline freeze
  logic              stall_if;
  logic              stall_mem;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  // pipeline stages and memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM single-port memory arbiter with data priority and anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  // lat_cnt value in the cycle mem_rdata is valid, and in the ack cycle
  localparam logic [LAT_W-1:0] LAT_CAP  = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  state_t            state_nx;
  logic [LAT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              owner_if;
  logic              grant;
  logic              grant_if;
  logic              capture;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              if_ack_r;
  logic              d_ack_r;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state, grant decision and capture strobe
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_if = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant    = 1'b1;
          // data wins unless IF has been passed over STARVE_MAX times
          grant_if = bus.if_req && ((starve_cnt == STV_MAX) || !bus.d_req);
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        capture = (lat_cnt == LAT_CAP);
        // stay through the ack cycle so the next grant sees the requester's next request
        if (lat_cnt == LAT_LAST) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // memory port, latency counter, starvation counter, read data and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_if    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
    end else begin
      mem_en_r <= grant;
      if_ack_r <= capture && owner_if;
      d_ack_r  <= capture && !owner_if;
      lat_cnt  <= (state == WAIT) ? lat_cnt + LAT_W'(1) : '0;

      if (grant) begin
        owner_if    <= grant_if;
        mem_we_r    <= grant_if ? 1'b0 : bus.d_we;
        mem_addr_r  <= grant_if ? bus.if_addr : bus.d_addr;
        mem_wdata_r <= grant_if ? '0 : bus.d_wdata;
        if (grant_if) begin
          starve_cnt <= '0;
        end else if (bus.if_req && (starve_cnt != STV_MAX)) begin
          starve_cnt <= starve_cnt + STV_W'(1);
        end
      end

      if (capture && !mem_we_r) begin
        if (owner_if) begin
          if_rdata_r <= bus.mem_rdata;
        end else begin
          d_rdata_r <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.if_ack    = if_ack_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.stall_if  = bus.if_req & ~if_ack_r;
  assign bus.stall_mem = bus.d_req & ~d_ack_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // initial memory image, also used to seed the reference model
  function automatic logic [31:0] init_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    return {8'(a), 8'(~a), 8'(a ^ 'h5A), 8'hC3};
  endfunction

  // memory: MEM_LAT-deep read pipeline, junk on mem_rdata when nothing is due
  logic [31:0] mem     [256];
  bit          written [256];
  logic [31:0] pipe_d  [MEM_LAT];
  logic        pipe_v  [MEM_LAT];
  logic [31:0] junk;
  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
    pipe_v[0] <= bus.mem_en && !bus.mem_we;
    pipe_d[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(int'(bus.mem_addr));
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
  end
  assign bus.mem_rdata = (pipe_v[MEM_LAT-1] === 1'b1) ? pipe_d[MEM_LAT-1] : junk;

  // reference model
  logic [31:0] ref_mem [256];
  logic [31:0] last_d;
  logic [31:0] if_q [$];
  logic [31:0] d_q  [$];
  bit          grant_log [$];
  int          starve;
  bit          pend_v;
  int          pend_cycle;
  bit          pend_if;
  logic        p_if, p_d, p_d_we;
  logic [7:0]  p_if_addr, p_d_addr;
  logic [31:0] p_d_wdata;

  // monitor: ack timing, stalls, read data, grant order
  always @(negedge clk) begin
    logic exp_if_ack;
    logic exp_d_ack;
    bit   want_if;
    if (reset) begin
      pend_v = 1'b0;
      starve = 0;
    end else begin
      exp_if_ack = pend_v && (cycle == pend_cycle) && pend_if;
      exp_d_ack  = pend_v && (cycle == pend_cycle) && !pend_if;
      if (pend_v && cycle == pend_cycle) pend_v = 1'b0;
      chk("if_ack", bus.if_ack, exp_if_ack);
      chk("d_ack", bus.d_ack, exp_d_ack);
      chk("stall_if", bus.stall_if, bus.if_req & ~exp_if_ack);
      chk("stall_mem", bus.stall_mem, bus.d_req & ~exp_d_ack);
      if (bus.if_ack) begin
        if (if_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL if_ack_unexpected: got ack expected none (cycle %0d)", cycle);
        end else chk("if_rdata", bus.if_rdata, if_q.pop_front());
      end
      if (bus.d_ack) begin
        if (d_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL d_ack_unexpected: got ack expected none (cycle %0d)", cycle);
        end else chk("d_rdata", bus.d_rdata, d_q.pop_front());
      end
      if (bus.mem_en) begin
        chk("mem_en_overlap", pend_v, 1'b0);
        if (!p_if && !p_d) begin
          errors++; checks++;
          $display("FAIL spurious_mem_en: got mem_en=1 expected 0 (cycle %0d)", cycle);
        end else begin
          if (p_if && starve == STARVE_MAX) want_if = 1'b1;
          else if (p_d) want_if = 1'b0;
          else want_if = 1'b1;
          if (want_if) starve = 0;
          else if (p_if) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
          grant_log.push_back(want_if);
          chk("mem_addr", bus.mem_addr, want_if ? p_if_addr : p_d_addr);
          chk("mem_we", bus.mem_we, want_if ? 1'b0 : p_d_we);
          if (!want_if && p_d_we) chk("mem_wdata", bus.mem_wdata, p_d_wdata);
          pend_v     = 1'b1;
          pend_cycle = cycle + MEM_LAT + 1;
          pend_if    = want_if;
        end
      end
    end
    p_if = bus.if_req; p_d = bus.d_req; p_d_we = bus.d_we;
    p_if_addr = bus.if_addr; p_d_addr = bus.d_addr; p_d_wdata = bus.d_wdata;
  end

  // IF requester: assumes entry just after a rising edge; returns request-to-ack cycles
  task automatic if_txn(input logic [7:0] addr, output int lat);
    int t0;
    int n;
    t0 = cycle;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    if_q.push_back(ref_mem[addr]);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_ack && n < 400);
    if (!bus.if_ack) begin
      errors++; checks++;
      $display("FAIL if_timeout: got no if_ack expected one within 400 cycles");
    end
    lat = cycle - t0;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  // MEM-stage requester
  task automatic d_txn(input logic we, input logic [7:0] addr, input logic [31:0] wdata, output int lat);
    int t0;
    int n;
    t0 = cycle;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    if (we) ref_mem[addr] = wdata;
    else last_d = ref_mem[addr];
    d_q.push_back(last_d);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_ack && n < 400);
    if (!bus.d_ack) begin
      errors++; checks++;
      $display("FAIL d_timeout: got no d_ack expected one within 400 cycles");
    end
    lat = cycle - t0;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  initial begin
    int lat_a, lat_b, lat_c;
    bit exp_seq [7];
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < MEM_LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
    last_d = '0;

    // reset held with both requests pending
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h90; bus.d_wdata = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_en", bus.mem_en, 1'b0);
      chk("rst_if_ack", bus.if_ack, 1'b0);
      chk("rst_d_ack", bus.d_ack, 1'b0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // simultaneous requests: data first, IF right after
    fork
      if_txn(8'h10, lat_a);
      d_txn(1'b0, 8'h90, 32'h0, lat_b);
    join
    chk("simul_d_lat", lat_b, MEM_LAT + 2);
    chk("simul_if_lat", lat_a, 2 * MEM_LAT + 5);

    // single IF read
    if_txn(8'h10, lat_a);
    chk("if_read_lat", lat_a, MEM_LAT + 2);

    // write then read back on the data port
    d_txn(1'b1, 8'h20, 32'h00001234, lat_b);
    chk("d_write_lat", lat_b, MEM_LAT + 2);
    d_txn(1'b0, 8'h20, 32'h0, lat_b);
    chk("d_read_lat", lat_b, MEM_LAT + 2);

    // starvation: continuous data traffic against one IF request
    grant_log.delete();
    fork
      if_txn(8'h10, lat_a);
      for (int i = 0; i < 6; i++) d_txn(1'b0, 8'(8'h80 + i * 4), 32'h0, lat_c);
    join
    if (grant_log.size() < 7) begin
      errors++; checks++;
      $display("FAIL grant_count: got %0d expected 7", grant_log.size());
    end else begin
      for (int i = 0; i < 7; i++) chk($sformatf("grant_seq_%0d", i), grant_log[i], exp_seq[i]);
    end
    chk("starve_cnt_clear", u_dut.starve_cnt, 0);

    // reset one cycle after ISSUE of an IF read
    bus.if_req = 1'b1; bus.if_addr = 8'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; bus.if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    if_q.delete(); d_q.delete(); last_d = '0;
    repeat (MEM_LAT + 4) begin
      @(negedge clk);
      chk("abort_mem_en", bus.mem_en, 1'b0);
      chk("abort_if_ack", bus.if_ack, 1'b0);
      chk("abort_if_rdata", bus.if_rdata, 32'h0);
      chk("abort_d_rdata", bus.d_rdata, 32'h0);
    end
    @(posedge clk); #1;
    if_txn(8'h10, lat_a);
    chk("post_reset_if_lat", lat_a, MEM_LAT + 2);

    // randomized traffic on both ports
    fork
      for (int k = 0; k < 40; k++) begin
        int g;
        int l;
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
        if_txn(8'($urandom_range(0, 127)), l);
      end
      for (int k = 0; k < 40; k++) begin
        int g;
        int l;
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
        d_txn(1'($urandom_range(0, 1)), 8'(8'h80 | $urandom_range(0, 127)), $urandom, l);
      end
    join

    repeat (MEM_LAT + 4) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end
endmodule
